// File: rtl/ex_stage_unit.sv
`timescale 1ns/1ps
// ex_stage_unit
// Execute stage that sits between the ID/EX and EX/MEM pipeline registers.
// It takes the decoded ID/EX bundle, runs it through the ALU and loads the
// EX/MEM register. Single-cycle ops are add, sub, and, or, slt, sll and srl.
// MUL is a 16-step shift-add sequence that holds ID/EX through stallEx.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   hit                 0 = memory miss, every register in this block holds
//   flush               1 = squash: EX/MEM loads a bubble, any MUL is dropped
//   nextinst            PC+1 of the instruction in ID/EX
//   regDst .. branch    ID/EX control bits
//   ALUOp, opCode       ALU operation select
//   readData1/2         operand A and the rs2 value
//   signExtend          sign-extended immediate
//   rt, rd              destination register candidates
//   stallEx             hold ID/EX this cycle (combinational)
//   aluResult, zero     EX/MEM result and its zero flag
//   branchTarget        EX/MEM nextinst + signExtend
//   writeData           EX/MEM store data (readData2)
//   writeReg            EX/MEM destination (regDst ? rd : rt)
//   *Out                EX/MEM control bits
module ex_stage_unit #(
  parameter int WIDTH  = 16,
  parameter int REGW   = 3,
  parameter int MULCYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit,
  input  logic             flush,
  input  logic [WIDTH-1:0] nextinst,
  input  logic             regDst,
  input  logic             ALUSrc,
  input  logic             memtoReg,
  input  logic             regWrite,
  input  logic             memRead,
  input  logic             memWrite,
  input  logic             branch,
  input  logic [1:0]       ALUOp,
  input  logic [2:0]       opCode,
  input  logic [WIDTH-1:0] readData1,
  input  logic [WIDTH-1:0] readData2,
  input  logic [WIDTH-1:0] signExtend,
  input  logic [REGW-1:0]  rt,
  input  logic [REGW-1:0]  rd,
  output logic             stallEx,
  output logic [WIDTH-1:0] aluResult,
  output logic             zero,
  output logic [WIDTH-1:0] branchTarget,
  output logic [WIDTH-1:0] writeData,
  output logic [REGW-1:0]  writeReg,
  output logic             memtoRegOut,
  output logic             regWriteOut,
  output logic             memReadOut,
  output logic             memWriteOut,
  output logic             branchOut
);

  localparam int CNTW = (MULCYC > 1) ? $clog2(MULCYC) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(MULCYC - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  // ctl order: {memtoReg, regWrite, memRead, memWrite, branch}
  typedef struct packed {
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] bt;
    logic [WIDTH-1:0] wd;
    logic [REGW-1:0]  wr;
    logic [4:0]       ctl;
  } exmem_t;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [REGW-1:0]  mul_wr_q, mul_wr_d;
  logic [4:0]       mul_ctl_q, mul_ctl_d;
  exmem_t           exmem_q, exmem_d;

  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_next;
  logic [REGW-1:0]  wr_sel;
  logic [4:0]       ctl_in;
  logic [3:0]       shamt;
  logic             lt;
  logic             is_mul;

  assign op_b   = ALUSrc ? signExtend : readData2;
  assign wr_sel = regDst ? rd : rt;
  assign ctl_in = {memtoReg, regWrite, memRead, memWrite, branch};
  assign shamt  = op_b[3:0];
  assign lt     = $signed(readData1) < $signed(op_b);
  // A MUL opcode only starts the sequencer when it actually writes a register.
  assign is_mul = ALUOp[1] & (opCode == 3'b110) & regWrite;

  // Single-cycle ALU. The mul opcode yields 0 here: it only reaches this path
  // when regWrite is clear, so the value is never consumed.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    alu_res = '0;
    if (ALUOp == 2'b00) begin
      alu_res = readData1 + op_b;
    end else if (ALUOp == 2'b01) begin
      alu_res = readData1 - op_b;
    end else begin
      case (opCode)
        3'b000:  alu_res = readData1 + op_b;
        3'b001:  alu_res = readData1 - op_b;
        3'b010:  alu_res = readData1 & op_b;
        3'b011:  alu_res = readData1 | op_b;
        3'b100:  alu_res = {{(WIDTH-1){1'b0}}, lt};
        3'b101:  alu_res = readData1 << shamt;
        3'b111:  alu_res = readData1 >> shamt;
        default: alu_res = '0;
      endcase
    end
  end

  // Partial product including the current multiplier bit; on the last step
  // this is the value that retires.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    mul_wr_d  = mul_wr_q;
    mul_ctl_d = mul_ctl_q;
    exmem_d   = exmem_q;

    if (flush) begin
      exmem_d = '0;
      state_d = IDLE;
      cnt_d   = '0;
    end else if (hit) begin
      case (state_q)
        IDLE: begin
          if (is_mul) begin
            mcand_d   = readData1;
            mplier_d  = op_b;
            acc_d     = '0;
            cnt_d     = '0;
            mul_wr_d  = wr_sel;
            mul_ctl_d = ctl_in;
            exmem_d   = '0;
            state_d   = BUSY;
          end else begin
            exmem_d = '{alu: alu_res, bt: nextinst + signExtend,
                        wd: readData2, wr: wr_sel, ctl: ctl_in};
          end
        end
        BUSY: begin
          acc_d    = acc_next;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          exmem_d  = '0;
          if (cnt_q == LAST) begin
            exmem_d = '{alu: acc_next, bt: '0, wd: '0,
                        wr: mul_wr_q, ctl: mul_ctl_q};
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      mul_wr_q  <= '0;
      mul_ctl_q <= '0;
      exmem_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      mul_wr_q  <= mul_wr_d;
      mul_ctl_q <= mul_ctl_d;
      exmem_q   <= exmem_d;
    end
  end

  // Drops in the final MUL step so ID/EX advances on the edge the product retires.
  assign stallEx = ((state_q == IDLE) && is_mul) ||
                   ((state_q == BUSY) && (cnt_q != LAST));

  assign aluResult    = exmem_q.alu;
  assign zero         = (exmem_q.alu == '0);
  assign branchTarget = exmem_q.bt;
  assign writeData    = exmem_q.wd;
  assign writeReg     = exmem_q.wr;
  assign {memtoRegOut, regWriteOut, memReadOut, memWriteOut, branchOut} = exmem_q.ctl;

endmodule

// File: tb/tb_ex_stage_unit.sv
`timescale 1ns/1ps
// tb_ex_stage_unit
// Directed vectors for ex_stage_unit. The driver pushes the expected EX/MEM
// contents when it issues an instruction; an independent monitor pops and
// compares whenever the stage retires a non-bubble.
module tb_ex_stage_unit;

  logic        clk;
  logic        rst_n;
  logic        hit;
  logic        flush;
  logic [15:0] nextinst;
  logic        regDst, ALUSrc, memtoReg, regWrite, memRead, memWrite, branch;
  logic [1:0]  ALUOp;
  logic [2:0]  opCode;
  logic [15:0] readData1, readData2, signExtend;
  logic [2:0]  rt, rd;
  logic        stallEx;
  logic [15:0] aluResult;
  logic        zero;
  logic [15:0] branchTarget;
  logic [15:0] writeData;
  logic [2:0]  writeReg;
  logic        memtoRegOut, regWriteOut, memReadOut, memWriteOut, branchOut;

  ex_stage_unit #(.WIDTH(16), .REGW(3), .MULCYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .hit(hit), .flush(flush), .nextinst(nextinst),
    .regDst(regDst), .ALUSrc(ALUSrc), .memtoReg(memtoReg), .regWrite(regWrite),
    .memRead(memRead), .memWrite(memWrite), .branch(branch), .ALUOp(ALUOp),
    .opCode(opCode), .readData1(readData1), .readData2(readData2),
    .signExtend(signExtend), .rt(rt), .rd(rd), .stallEx(stallEx),
    .aluResult(aluResult), .zero(zero), .branchTarget(branchTarget),
    .writeData(writeData), .writeReg(writeReg), .memtoRegOut(memtoRegOut),
    .regWriteOut(regWriteOut), .memReadOut(memReadOut),
    .memWriteOut(memWriteOut), .branchOut(branchOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl order: {memtoReg, regWrite, memRead, memWrite, branch}
  typedef struct {
    logic [1:0]  aluop;
    logic [2:0]  op;
    logic [15:0] a, b, imm, pc;
    logic        alusrc, regdst;
    logic [2:0]  rt, rd;
    logic [4:0]  ctl;
  } instr_t;

  typedef struct {
    logic [15:0] alu, bt, wd;
    logic [2:0]  wr;
    logic [4:0]  ctl;
    bit          data_care;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   bubbles  = 0;
  int   spurious = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  function automatic instr_t mk(input logic [1:0] aluop, input logic [2:0] op,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic alusrc, input logic [15:0] imm,
                                input logic [15:0] pc, input logic regdst,
                                input logic [2:0] rt_i, input logic [2:0] rd_i,
                                input logic [4:0] ctl);
    instr_t i;
    i.aluop = aluop; i.op = op; i.a = a; i.b = b; i.alusrc = alusrc;
    i.imm = imm; i.pc = pc; i.regdst = regdst; i.rt = rt_i; i.rd = rd_i; i.ctl = ctl;
    return i;
  endfunction

  function automatic exp_t mke(input logic [15:0] alu, input logic [15:0] bt,
                               input logic [15:0] wd, input logic [2:0] wr,
                               input logic [4:0] ctl, input bit care);
    exp_t e;
    e.alu = alu; e.bt = bt; e.wd = wd; e.wr = wr; e.ctl = ctl; e.data_care = care;
    return e;
  endfunction

  task automatic drive(input instr_t i);
    ALUOp = i.aluop; opCode = i.op; readData1 = i.a; readData2 = i.b;
    ALUSrc = i.alusrc; signExtend = i.imm; nextinst = i.pc; regDst = i.regdst;
    rt = i.rt; rd = i.rd;
    {memtoReg, regWrite, memRead, memWrite, branch} = i.ctl;
  endtask

  task automatic drive_bubble();
    drive(mk(2'b00, 3'b000, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 3'd0, 5'b0));
  endtask

  // Call at posedge+1. Holds the instruction until an edge with stallEx low and
  // hit high consumes it, optionally dropping hit for edges [lo_at, lo_at+lo_len).
  task automatic issue(input instr_t i, input exp_t e, input int lo_at, input int lo_len,
                       output int edges, output int stalls, output int bub0);
    bit s;
    bit done;
    drive(i);
    sb_q.push_back(e);
    edges = 0; stalls = 0; bub0 = bubbles; done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      hit = !(lo_len > 0 && edges + 1 >= lo_at && edges + 1 < lo_at + lo_len);
      @(negedge clk); #1;
      if (k == 0) bub0 = bubbles;
      s = stallEx;
      if (s) stalls++;
      @(posedge clk); #1;
      edges++;
      if (!s && hit) done = 1'b1;
    end
    hit = 1'b1;
    drive_bubble();
    if (!done) check("issue_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: edges that actually load EX/MEM are examined at the following negedge.
  initial begin
    logic act_edge;
    exp_t e;
    forever begin
      @(posedge clk);
      act_edge = rst_n && (hit || flush);
      @(negedge clk);
      if (act_edge) begin
        if ({memtoRegOut, regWriteOut, memReadOut, memWriteOut, branchOut} != 5'b0) begin
          if (sb_q.size() == 0) begin
            spurious++;
            check("spurious_output", 32'(aluResult), 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("aluResult", 32'(aluResult), 32'(e.alu));
            check("writeReg", 32'(writeReg), 32'(e.wr));
            check("ctl_out", 32'({memtoRegOut, regWriteOut, memReadOut, memWriteOut, branchOut}),
                  32'(e.ctl));
            check("zero", 32'(zero), 32'(e.alu == 16'h0));
            if (e.data_care) begin
              check("branchTarget", 32'(branchTarget), 32'(e.bt));
              check("writeData", 32'(writeData), 32'(e.wd));
            end
          end
        end else begin
          bubbles++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  instr_t vec[10];
  exp_t   ev[10];

  initial begin
    int edges, stalls, bub0;
    instr_t mul_i;

    rst_n = 1'b0; hit = 1'b1; flush = 1'b0;
    drive_bubble();

    // Reset: two edges low, then release.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_aluResult", 32'(aluResult), 32'd0);
    check("rst_branchTarget", 32'(branchTarget), 32'd0);
    check("rst_writeData", 32'(writeData), 32'd0);
    check("rst_writeReg", 32'(writeReg), 32'd0);
    check("rst_ctl", 32'({memtoRegOut, regWriteOut, memReadOut, memWriteOut, branchOut}), 32'd0);
    check("rst_stallEx", 32'(stallEx), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);   // aluResult is 0 after reset
    @(posedge clk); #1;

    // Single-cycle vectors: {memtoReg, regWrite, memRead, memWrite, branch}
    vec[0] = mk(2'b10, 3'b000, 16'h7FFF, 16'h0001, 1'b0, 16'h0003, 16'h0010, 1'b1, 3'd2, 3'd5, 5'b01000);
    ev[0]  = mke(16'h8000, 16'h0013, 16'h0001, 3'd5, 5'b01000, 1'b1);
    vec[1] = mk(2'b01, 3'b000, 16'h1234, 16'h1234, 1'b0, 16'hFFFE, 16'h0002, 1'b0, 3'd3, 3'd6, 5'b00001);
    ev[1]  = mke(16'h0000, 16'h0000, 16'h1234, 3'd3, 5'b00001, 1'b1);
    vec[2] = mk(2'b10, 3'b010, 16'hF0F0, 16'h3C3C, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd0, 3'd1, 5'b01000);
    ev[2]  = mke(16'h3030, 16'h0000, 16'h3C3C, 3'd1, 5'b01000, 1'b1);
    vec[3] = mk(2'b10, 3'b011, 16'hF0F0, 16'h0F01, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd0, 3'd2, 5'b01000);
    ev[3]  = mke(16'hFFF1, 16'h0000, 16'h0F01, 3'd2, 5'b01000, 1'b1);
    vec[4] = mk(2'b10, 3'b100, 16'hFFFE, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd0, 3'd4, 5'b01000);
    ev[4]  = mke(16'h0001, 16'h0000, 16'h0001, 3'd4, 5'b01000, 1'b1);
    vec[5] = mk(2'b10, 3'b100, 16'h0001, 16'hFFFE, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd0, 3'd7, 5'b01000);
    ev[5]  = mke(16'h0000, 16'h0000, 16'hFFFE, 3'd7, 5'b01000, 1'b1);
    vec[6] = mk(2'b10, 3'b101, 16'h0003, 16'hAAAA, 1'b1, 16'h0014, 16'h0100, 1'b0, 3'd6, 3'd1, 5'b01000);
    ev[6]  = mke(16'h0030, 16'h0114, 16'hAAAA, 3'd6, 5'b01000, 1'b1);
    vec[7] = mk(2'b10, 3'b111, 16'h8000, 16'h000F, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd0, 3'd3, 5'b01000);
    ev[7]  = mke(16'h0001, 16'h0000, 16'h000F, 3'd3, 5'b01000, 1'b1);
    vec[8] = mk(2'b00, 3'b111, 16'h1000, 16'h5555, 1'b1, 16'hFFFC, 16'h0000, 1'b0, 3'd1, 3'd4, 5'b11100);
    ev[8]  = mke(16'h0FFC, 16'hFFFC, 16'h5555, 3'd1, 5'b11100, 1'b1);
    vec[9] = mk(2'b00, 3'b000, 16'hFFFF, 16'hBEEF, 1'b1, 16'h0002, 16'hFFFF, 1'b0, 3'd2, 3'd5, 5'b00010);
    ev[9]  = mke(16'h0001, 16'h0001, 16'hBEEF, 3'd2, 5'b00010, 1'b1);

    for (int v = 0; v < 10; v++) begin
      issue(vec[v], ev[v], 0, 0, edges, stalls, bub0);
      check($sformatf("alu_latency_%0d", v), 32'(edges), 32'd1);
    end

    // MUL 300 * 7 = 2100: 16 stall cycles, 16 bubbles, product on the 17th edge.
    mul_i = mk(2'b10, 3'b110, 16'd300, 16'd7, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd0, 3'd5, 5'b01000);
    issue(mul_i, mke(16'd2100, 16'h0, 16'h0, 3'd5, 5'b01000, 1'b0), 0, 0, edges, stalls, bub0);
    @(negedge clk); #1;
    check("mul_edges", 32'(edges), 32'd17);
    check("mul_stalls", 32'(stalls), 32'd16);
    check("mul_bubbles", 32'(bubbles - bub0), 32'd16);
    @(posedge clk); #1;

    // MUL 0xFFFF * 0xFFFF with hit low on edges 6..8: three edges late, stall held.
    mul_i = mk(2'b10, 3'b110, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd0, 3'd3, 5'b01000);
    issue(mul_i, mke(16'h0001, 16'h0, 16'h0, 3'd3, 5'b01000, 1'b0), 6, 3, edges, stalls, bub0);
    @(negedge clk); #1;
    check("mul_freeze_edges", 32'(edges), 32'd20);
    check("mul_freeze_stalls", 32'(stalls), 32'd19);
    check("mul_freeze_bubbles", 32'(bubbles - bub0), 32'd16);
    @(posedge clk); #1;

    // Flush with the MUL at cnt=8 (issue edge + 8 BUSY edges).
    drive(mk(2'b10, 3'b110, 16'h0005, 16'h0009, 1'b0, 16'h0, 16'h0, 1'b1, 3'd0, 3'd6, 5'b01000));
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    drive_bubble();
    @(negedge clk);
    check("pre_flush_stall", 32'(stallEx), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_stallEx", 32'(stallEx), 32'd0);
    check("flush_ctl", 32'({memtoRegOut, regWriteOut, memReadOut, memWriteOut, branchOut}), 32'd0);
    @(posedge clk); #1;
    issue(mk(2'b10, 3'b000, 16'h0002, 16'h0003, 1'b0, 16'h0, 16'h0, 1'b1, 3'd0, 3'd2, 5'b01000),
          mke(16'h0005, 16'h0, 16'h0003, 3'd2, 5'b01000, 1'b1), 0, 0, edges, stalls, bub0);
    check("post_flush_latency", 32'(edges), 32'd1);

    // Reset in the middle of a second MUL.
    drive(mk(2'b10, 3'b110, 16'h0003, 16'h0004, 1'b0, 16'h0, 16'h0, 1'b1, 3'd0, 3'd7, 5'b01000));
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    drive_bubble();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_aluResult", 32'(aluResult), 32'd0);
    check("midrst_ctl", 32'({memtoRegOut, regWriteOut, memReadOut, memWriteOut, branchOut}), 32'd0);
    check("midrst_stallEx", 32'(stallEx), 32'd0);
    repeat (25) @(posedge clk);
    #1;
    issue(mk(2'b01, 3'b000, 16'h0010, 16'h0001, 1'b0, 16'h0, 16'h0, 1'b1, 3'd0, 3'd4, 5'b01000),
          mke(16'h000F, 16'h0, 16'h0001, 3'd4, 5'b01000, 1'b1), 0, 0, edges, stalls, bub0);
    check("post_rst_latency", 32'(edges), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;

    check("no_spurious", 32'(spurious), 32'd0);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
